// File: rtl/neopixel_ctrl_if.sv
// PicoRV32-style peripheral bus: single pre-decoded select, held until ready.
interface neopixel_ctrl_if;
  logic        sel;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;
  logic        ready;

  modport master (
    output sel, addr, wdata, wstrb,
    input  rdata, ready
  );

  modport slave (
    input  sel, addr, wdata, wstrb,
    output rdata, ready
  );
endinterface

// File: rtl/neopixel_ctrl.sv
// Bus front end for a WS2812 serial driver: CPU-written staging buffer,
// commit-triggered snapshot into the driver frame register, start/busy
// handshake with retry, and a latch gap between frames.
module neopixel_ctrl #(
  parameter int nbr_pixels    = 1,
  parameter int RESET_CYCLES  = 1000,
  parameter int START_TIMEOUT = 4
) (
  input  logic                      clk_16MHz,
  input  logic                      resetn,
  neopixel_ctrl_if.slave            bus,
  output logic [nbr_pixels*24-1:0]  pix_data,
  output logic                      start_tx,
  input  logic                      busy
);

  localparam int CNT_MAX = (RESET_CYCLES > START_TIMEOUT) ? RESET_CYCLES : START_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int PW      = nbr_pixels * 24;

  typedef enum logic [2:0] {IDLE, START, RETRY, TX, LATCH} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               pending_reg, pending_next;
  logic               start_tx_reg, start_tx_next;
  logic               ready_reg;
  logic [31:0]        rdata_reg, rdata_next;
  logic [PW-1:0]      pix_data_reg;
  logic [PW-1:0]      staging_flat;
  logic               access;
  logic               commit;
  logic               copy;

  // Bits of the bus that carry no meaning for this peripheral.
  logic unused_bits;
  assign unused_bits = &{1'b0, bus.wstrb[3], bus.wdata[31:24]};

  // An access is serviced on the single edge where sel is high and ready is not yet.
  assign access = bus.sel & ~ready_reg;
  assign commit = access & (bus.addr == 8'd0) & bus.wstrb[0] & bus.wdata[0];

  // One staging register per pixel; pixel 0 lands in the top 24 bits of the frame.
  generate
    for (genvar gi = 0; gi < nbr_pixels; gi++) begin : g_pix
      localparam logic [7:0] PIX_ADDR = 8'(gi + 1);
      logic [23:0] pix_reg;
      logic        hit;
      assign hit = access & (bus.addr == PIX_ADDR);

      // Byte-strobed update of this pixel; the top strobe has no byte to hit.
      always_ff @(posedge clk_16MHz or negedge resetn) begin
        if (!resetn) begin
          pix_reg <= '0;
        end else if (hit) begin
          for (int b = 0; b < 3; b++) begin
            if (bus.wstrb[b]) pix_reg[8*b +: 8] <= bus.wdata[8*b +: 8];
          end
        end
      end

      assign staging_flat[24*(nbr_pixels-gi)-1 -: 24] = pix_reg;
    end
  endgenerate

  // Read mux: status at word 0, pixels at 1..nbr_pixels, zero elsewhere.
  always_comb begin
    rdata_next = '0;
    if (bus.addr == 8'd0) begin
      rdata_next = {30'd0, pending_reg, (state_reg != IDLE)};
    end
    for (int i = 0; i < nbr_pixels; i++) begin
      if (bus.addr == 8'(i + 1)) rdata_next = {8'd0, staging_flat[24*(nbr_pixels-i)-1 -: 24]};
    end
  end

  // Bus acknowledge and registered read data.
  always_ff @(posedge clk_16MHz or negedge resetn) begin
    if (!resetn) begin
      ready_reg <= 1'b0;
      rdata_reg <= '0;
    end else begin
      ready_reg <= bus.sel & ~ready_reg;
      if (access) rdata_reg <= rdata_next;
    end
  end

  // Frame FSM next state; a commit landing on the copy cycle keeps pending set.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    copy       = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (pending_reg && !busy) begin
          copy       = 1'b1;
          cnt_next   = '0;
          state_next = START;
        end
      end
      START: begin
        if (busy) begin
          state_next = TX;
        end else if (cnt_reg == CNT_W'(START_TIMEOUT - 1)) begin
          cnt_next   = '0;
          state_next = RETRY;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      RETRY: begin
        cnt_next   = '0;
        state_next = START;
      end
      TX: begin
        if (!busy) begin
          cnt_next   = '0;
          state_next = LATCH;
        end
      end
      LATCH: begin
        if (cnt_reg == CNT_W'(RESET_CYCLES - 1)) begin
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    start_tx_next = (state_next == START);
    pending_next  = commit | (pending_reg & ~copy);
  end

  // FSM state, counter, pending flag, start request and the frame snapshot.
  always_ff @(posedge clk_16MHz or negedge resetn) begin
    if (!resetn) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      pending_reg  <= 1'b0;
      start_tx_reg <= 1'b0;
      pix_data_reg <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      pending_reg  <= pending_next;
      start_tx_reg <= start_tx_next;
      if (copy) pix_data_reg <= staging_flat;
    end
  end

  assign bus.ready = ready_reg;
  assign bus.rdata = rdata_reg;
  assign start_tx  = start_tx_reg;
  assign pix_data  = pix_data_reg;

endmodule

// File: tb/tb_neopixel_ctrl.sv
// Directed bench for neopixel_ctrl with a behavioural WS2812 driver model.
module tb_neopixel_ctrl;
  localparam int NP      = 2;
  localparam int RC      = 20;
  localparam int ST      = 4;
  localparam int BIT_CYC = 3;
  localparam int PW      = NP * 24;

  logic          clk_16MHz = 1'b0;
  logic          resetn;
  logic          busy;
  logic          start_tx;
  logic [PW-1:0] pix_data;

  neopixel_ctrl_if bus_if();

  neopixel_ctrl #(.nbr_pixels(NP), .RESET_CYCLES(RC), .START_TIMEOUT(ST)) dut (
    .clk_16MHz(clk_16MHz),
    .resetn(resetn),
    .bus(bus_if),
    .pix_data(pix_data),
    .start_tx(start_tx),
    .busy(busy)
  );

  always #31 clk_16MHz = ~clk_16MHz;

  int cyc = 0;
  always @(posedge clk_16MHz) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Driver model: raises busy on start_tx, shifts the frame out MSB first.
  // When stuck, it ignores start_tx until it sees start_tx fall.
  logic          stuck = 1'b0;
  logic          prev_start = 1'b0;
  int            frames = 0;
  int            fall_cyc = 0;
  logic [PW-1:0] cap = '0;

  initial begin
    busy = 1'b0;
    forever begin
      @(posedge clk_16MHz); #1;
      if (stuck) begin
        if (prev_start && start_tx !== 1'b1) stuck = 1'b0;
      end else if (start_tx === 1'b1 && !busy) begin
        busy = 1'b1;
        frames++;
        for (int b = 0; b < PW; b++) begin
          repeat (BIT_CYC) @(posedge clk_16MHz);
          #1;
          cap = {cap[PW-2:0], pix_data[PW-1-b]};
        end
        busy = 1'b0;
        fall_cyc = cyc;
      end
      prev_start = (start_tx === 1'b1);
    end
  end

  // One bus transaction; returns with sel dropped, #1 after the ready edge.
  task automatic bus_access(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [31:0] rd, output logic rdy_early, output logic rdy);
    @(posedge clk_16MHz); #1;
    bus_if.sel   = 1'b1;
    bus_if.addr  = a;
    bus_if.wdata = d;
    bus_if.wstrb = s;
    rdy_early = bus_if.ready;
    @(posedge clk_16MHz); #1;
    rdy = bus_if.ready;
    rd  = bus_if.rdata;
    bus_if.sel   = 1'b0;
    bus_if.wstrb = 4'h0;
    $display("bus addr=%0d wdata=0x%08h wstrb=%b rdata=0x%08h ready=%0b", a, d, s, rd, rdy);
  endtask

  task automatic wait_busy(input logic val, input string tag);
    int n = 0;
    while (busy !== val && n < 2000) begin
      @(negedge clk_16MHz);
      n++;
    end
    check(tag, 64'(busy), 64'(val));
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (start_tx !== 1'b1 && n < 2000) begin
      @(negedge clk_16MHz);
      n++;
    end
    check(tag, 64'(start_tx), 64'(1));
  endtask

  initial begin
    logic [31:0] r;
    logic        e, rdy;
    logic [6:0]  pat;
    int          n0, t_rise;

    resetn       = 1'b0;
    bus_if.sel   = 1'b0;
    bus_if.addr  = 8'd0;
    bus_if.wdata = 32'd0;
    bus_if.wstrb = 4'h0;
    repeat (3) @(posedge clk_16MHz);
    #1 resetn = 1'b1;
    @(negedge clk_16MHz);
    check("rst_ready",    64'(bus_if.ready), 64'(0));
    check("rst_rdata",    64'(bus_if.rdata), 64'(0));
    check("rst_start_tx", 64'(start_tx),     64'(0));
    check("rst_pix_data", 64'(pix_data),     64'(0));

    // Read-back and access timing
    bus_access(8'd1, 32'h00123456, 4'hF, r, e, rdy);
    bus_access(8'd1, 32'h0, 4'h0, r, e, rdy);
    check("rd_ready_early", 64'(e),   64'(0));
    check("rd_ready",       64'(rdy), 64'(1));
    check("rd_word1",       64'(r),   64'h00123456);
    bus_access(8'd0, 32'h0, 4'h0, r, e, rdy);
    check("rd_status_idle", 64'(r), 64'(0));

    // Partial strobe: bytes 1 and 3 selected, byte 3 has no storage
    bus_access(8'd2, 32'h00AABBCC, 4'hF, r, e, rdy);
    bus_access(8'd2, 32'hFF112233, 4'b1010, r, e, rdy);
    bus_access(8'd2, 32'h0, 4'h0, r, e, rdy);
    check("partial_strobe", 64'(r), 64'h00AA22CC);

    // Out-of-range address
    bus_access(8'd3, 32'hDEADBEEF, 4'hF, r, e, rdy);
    check("oob_wr_ready", 64'(rdy), 64'(1));
    bus_access(8'd3, 32'h0, 4'h0, r, e, rdy);
    check("oob_rd_ready", 64'(rdy), 64'(1));
    check("oob_rd_zero",  64'(r),   64'(0));
    bus_access(8'd255, 32'h0, 4'h0, r, e, rdy);
    check("oob_ff_zero", 64'(r), 64'(0));
    bus_access(8'd1, 32'h0, 4'h0, r, e, rdy);
    check("oob_word1_kept", 64'(r), 64'h00123456);
    bus_access(8'd2, 32'h0, 4'h0, r, e, rdy);
    check("oob_word2_kept", 64'(r), 64'h00AA22CC);

    // Commit of a two-pixel frame
    bus_access(8'd1, 32'h00FF0000, 4'hF, r, e, rdy);
    bus_access(8'd2, 32'h000000AA, 4'hF, r, e, rdy);
    bus_access(8'd0, 32'h1, 4'h1, r, e, rdy);
    @(negedge clk_16MHz);
    check("pix_before_copy", 64'(pix_data), 64'(0));
    @(posedge clk_16MHz); @(negedge clk_16MHz);
    check("pix_after_commit", 64'(pix_data), 64'hFF00000000AA);
    check("start_tx_high",    64'(start_tx), 64'(1));
    @(posedge clk_16MHz); @(negedge clk_16MHz);
    check("start_tx_dropped", 64'(start_tx), 64'(0));
    check("busy_high",        64'(busy),     64'(1));

    // Double buffering while frame 1 is on the wire
    bus_access(8'd1, 32'h00010203, 4'hF, r, e, rdy);
    bus_access(8'd0, 32'h1, 4'h1, r, e, rdy);
    bus_access(8'd0, 32'h0, 4'h0, r, e, rdy);
    check("status_busy_pending", 64'(r),        64'(3));
    check("pix_held_in_tx",      64'(pix_data), 64'hFF00000000AA);
    wait_busy(1'b0, "frame1_end");
    check("frame1_bits", 64'(cap), 64'hFF00000000AA);
    wait_start("frame2_start");
    t_rise = cyc;
    // busy drops just after edge F, DUT sees it at F+1, start_tx rises RC+1 edges later
    check("latch_gap",   64'(t_rise - fall_cyc), 64'(RC + 2));
    check("frame2_pix",  64'(pix_data),          64'h0102030000AA);

    // Three commits during frame 2 collapse into one further frame
    @(negedge clk_16MHz);
    n0 = frames;
    bus_access(8'd0, 32'h1, 4'h1, r, e, rdy);
    bus_access(8'd0, 32'h1, 4'h1, r, e, rdy);
    bus_access(8'd0, 32'h1, 4'h1, r, e, rdy);
    check("busy_during_commits", 64'(busy), 64'(1));
    repeat (700) @(negedge clk_16MHz);
    check("one_more_frame", 64'(frames - n0), 64'(1));
    bus_access(8'd0, 32'h0, 4'h0, r, e, rdy);
    check("status_idle_after", 64'(r), 64'(0));

    // Reset in the middle of a frame, then retry against a parked driver
    bus_access(8'd2, 32'h00000055, 4'hF, r, e, rdy);
    bus_access(8'd0, 32'h1, 4'h1, r, e, rdy);
    wait_busy(1'b1, "frame4_start");
    repeat (10) @(posedge clk_16MHz);
    #1 resetn = 1'b0;
    #1;
    check("rst_mid_start_tx", 64'(start_tx), 64'(0));
    check("rst_mid_pix",      64'(pix_data), 64'(0));
    @(posedge clk_16MHz);
    #1 resetn = 1'b1;
    bus_access(8'd1, 32'h0, 4'h0, r, e, rdy);
    check("rst_mid_staging", 64'(r), 64'(0));
    wait_busy(1'b0, "frame4_end");
    @(negedge clk_16MHz);
    stuck = 1'b1;
    bus_access(8'd1, 32'h000A0B0C, 4'hF, r, e, rdy);
    bus_access(8'd0, 32'h1, 4'h1, r, e, rdy);
    pat = '0;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk_16MHz); @(negedge clk_16MHz);
      pat[6-k] = start_tx;
    end
    check("retry_pattern", 64'(pat),  64'(7'b1111010));
    check("retry_busy",    64'(busy), 64'(1));
    wait_busy(1'b0, "frame5_end");
    check("frame5_bits", 64'(cap), 64'h0A0B0C000000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
